// File: rtl/pc_gen_if.sv
// pc_gen_if: request/response bundle between the front-end control and pc_gen.
//   master drives stall, br_type, zero, neg, jump, jr, imm, j_index, jr_target (and exc, eret
//   when PC_EXC_EN is defined); slave drives pc, pc_plus4, redirect, misalign (and epc).
interface pc_gen_if #(parameter int ADDR_W = 32);
   logic              stall;
   logic [2:0]        br_type;
   logic              zero;
   logic              neg;
   logic              jump;
   logic              jr;
   logic [ADDR_W-1:0] imm;
   logic [25:0]       j_index;
   logic [ADDR_W-1:0] jr_target;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_plus4;
   logic              redirect;
   logic              misalign;
`ifdef PC_EXC_EN
   logic              exc;
   logic              eret;
   logic [ADDR_W-1:0] epc;
   modport master (output stall, br_type, zero, neg, jump, jr, imm, j_index, jr_target, exc, eret,
                   input pc, pc_plus4, redirect, misalign, epc);
   modport slave (input stall, br_type, zero, neg, jump, jr, imm, j_index, jr_target, exc, eret,
                  output pc, pc_plus4, redirect, misalign, epc);
`else
   modport master (output stall, br_type, zero, neg, jump, jr, imm, j_index, jr_target,
                   input pc, pc_plus4, redirect, misalign);
   modport slave (input stall, br_type, zero, neg, jump, jr, imm, j_index, jr_target,
                  output pc, pc_plus4, redirect, misalign);
`endif
endinterface

// File: rtl/pc_gen.sv
// pc_gen: PC register with next-PC resolution (branches, j/jal, jr, stall-buffered redirect).
//   clk, rst_n (synchronous active-low); bus (pc_gen_if.slave):
//   in  stall, br_type, zero, neg, jump, jr, imm, j_index, jr_target
//   out pc, pc_plus4, redirect, misalign
//   Define PC_EXC_EN to add exc/eret inputs, the epc output and the EXC_VECTOR parameter.
module pc_gen #(
   parameter int ADDR_W = 32,
`ifdef PC_EXC_EN
   parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'h0000_4180,
`endif
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000
) (
   input logic     clk,
   input logic     rst_n,
   pc_gen_if.slave bus
);
   logic [ADDR_W-1:0] pc, pc_plus4, pend_tgt, tgt, epc_val;
   logic              pend_v, redirect, misalign, taken, req, eret_req, mis_cap;
`ifdef PC_EXC_EN
   logic [ADDR_W-1:0] epc;
   assign eret_req = bus.eret;
   assign epc_val = epc;
   assign bus.epc = epc;
`else
   assign eret_req = 1'b0;
   assign epc_val = '0;
`endif
   assign pc_plus4 = pc + ADDR_W'(4);
   assign bus.pc = pc;
   assign bus.pc_plus4 = pc_plus4;
   assign bus.redirect = redirect;
   assign bus.misalign = misalign;
   always_comb
      case (bus.br_type)
         3'b001: taken = bus.zero;
         3'b010: taken = !bus.zero;
         3'b011: taken = bus.zero | bus.neg;
         3'b100: taken = !bus.zero & !bus.neg;
         3'b101: taken = bus.neg;
         3'b110: taken = !bus.neg;
         default: taken = 1'b0;
      endcase
   assign req = eret_req | bus.jr | bus.jump | taken;
   assign tgt = eret_req ? epc_val
              : bus.jr ? bus.jr_target & ~ADDR_W'(3)
              : bus.jump ? {pc_plus4[ADDR_W-1:28], bus.j_index, 2'b00}
              : taken ? pc_plus4 + (bus.imm << 2)
              : pc_plus4;
   // a jr is captured only when nothing is already pending and eret does not outrank it
   assign mis_cap = !pend_v & !eret_req & bus.jr & |bus.jr_target[1:0];
   always_ff @(posedge clk)
      if (!rst_n) begin
         pc <= RESET_PC;
         redirect <= 1'b0;
         misalign <= 1'b0;
         pend_v <= 1'b0;
         pend_tgt <= '0;
`ifdef PC_EXC_EN
         epc <= '0;
      end else if (bus.exc) begin
         pc <= EXC_VECTOR;
         epc <= pc;
         redirect <= 1'b1;
         misalign <= 1'b0;
         pend_v <= 1'b0;
`endif
      end else begin
         misalign <= mis_cap;
         if (!bus.stall) begin
            pc <= pend_v ? pend_tgt : tgt;
            redirect <= pend_v | req;
            pend_v <= 1'b0;
         end else begin
            redirect <= 1'b0;
            if (!pend_v && req) begin
               pend_tgt <= tgt;
               pend_v <= 1'b1;
            end
         end
      end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed and randomized checks of pc_gen against a queue-based next-PC model.
module tb_pc_gen;
   logic clk = 1'b0;
   logic rst_n;
   int checks = 0;
   int errors = 0;
   logic [31:0] mpc, mepc;
   logic mredir, mmis;
   logic [31:0] pend[$];

   always #5 clk = ~clk;

   pc_gen_if #(.ADDR_W(32)) bus();
   pc_gen dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // compare result modelled as a signed value: 0, negative or positive
   function automatic bit taken_f(input logic [2:0] bt, input int v);
      case (bt)
         3'd1: return v == 0;
         3'd2: return v != 0;
         3'd3: return v <= 0;
         3'd4: return v > 0;
         3'd5: return v < 0;
         3'd6: return v >= 0;
         default: return 1'b0;
      endcase
   endfunction

   task automatic set_cmp(input int v);
      bus.zero = (v == 0);
      bus.neg = (v < 0);
   endtask

   task automatic idle();
      bus.stall = 0;
      bus.br_type = 0;
      set_cmp(1);
      bus.jump = 0;
      bus.jr = 0;
      bus.imm = 0;
      bus.j_index = 0;
      bus.jr_target = 0;
`ifdef PC_EXC_EN
      bus.exc = 0;
      bus.eret = 0;
`endif
   endtask

   task automatic tick();
      logic [31:0] p4, t;
      logic req, mis, eret_v, exc_v;
      int v;
      @(posedge clk);
      eret_v = 0;
      exc_v = 0;
`ifdef PC_EXC_EN
      eret_v = bus.eret;
      exc_v = bus.exc;
`endif
      v = bus.zero ? 0 : (bus.neg ? -1 : 1);
      p4 = mpc + 4;
      req = 1;
      mis = 0;
      if (eret_v) t = mepc;
      else if (bus.jr) begin
         t = bus.jr_target - (bus.jr_target % 4);
         mis = (bus.jr_target % 4) != 0;
      end
      else if (bus.jump) t = (p4 & 32'hF000_0000) + bus.j_index * 4;
      else if (taken_f(bus.br_type, v)) t = p4 + bus.imm * 4;
      else begin
         req = 0;
         t = p4;
      end
      if (!rst_n) begin
         mpc = 32'h3000;
         mepc = 0;
         pend.delete();
         mredir = 0;
         mmis = 0;
      end else if (exc_v) begin
         mepc = mpc;
         mpc = 32'h4180;
         pend.delete();
         mredir = 1;
         mmis = 0;
      end else if (!bus.stall) begin
         if (pend.size() != 0) begin
            mpc = pend.pop_front();
            mredir = 1;
            mmis = 0;
         end else begin
            mpc = t;
            mredir = req;
            mmis = mis;
         end
      end else begin
         mredir = 0;
         mmis = (pend.size() == 0) && mis;
         if (pend.size() == 0 && req) pend.push_back(t);
      end
      #1;
      chk("pc", bus.pc, mpc);
      chk("pc_plus4", bus.pc_plus4, mpc + 32'd4);
      chk("redirect", 32'(bus.redirect), 32'(mredir));
      chk("misalign", 32'(bus.misalign), 32'(mmis));
`ifdef PC_EXC_EN
      chk("epc", bus.epc, mepc);
`endif
   endtask

   task automatic do_reset();
      rst_n = 0;
      idle();
      tick();
      rst_n = 1;
   endtask

   initial begin
      mpc = 0;
      mepc = 0;
      do_reset();
      chk("reset_pc", bus.pc, 32'h3000);
      chk("reset_redirect", 32'(bus.redirect), 32'd0);
      repeat (3) tick();
      chk("seq_pc", bus.pc, 32'h300C);
      for (int bt = 0; bt < 8; bt++)
         for (int v = -1; v <= 1; v++) begin
            do_reset();
            bus.br_type = 3'(bt);
            set_cmp(v);
            bus.imm = 32'hFFFF_FFFF;
            tick();
         end
      do_reset();
      bus.br_type = 3'd1;
      set_cmp(0);
      bus.imm = 32'hFFFF_FFFF;
      tick();
      chk("beq_taken_pc", bus.pc, 32'h3000);
      chk("beq_taken_redirect", 32'(bus.redirect), 32'd1);
      do_reset();
      bus.jump = 1;
      bus.j_index = 26'h0000C10;
      tick();
      chk("jump_pc", bus.pc, 32'h3040);
      do_reset();
      bus.jr = 1;
      bus.jr_target = 32'h4003;
      tick();
      chk("jr_pc", bus.pc, 32'h4000);
      chk("jr_misalign", 32'(bus.misalign), 32'd1);
      do_reset();
      bus.stall = 1;
      bus.jump = 1;
      bus.j_index = 26'h0000C10;
      tick();
      bus.jump = 0;
      bus.br_type = 3'd2;
      set_cmp(1);
      bus.imm = 32'd16;
      tick();
      tick();
      chk("stall_hold_pc", bus.pc, 32'h3000);
      idle();
      tick();
      chk("stall_drop_pc", bus.pc, 32'h3040);
      chk("stall_drop_redirect", 32'(bus.redirect), 32'd1);
      tick();
      do_reset();
      bus.jr = 1;
      bus.jr_target = 32'h5000;
      bus.jump = 1;
      bus.j_index = 26'h0000C10;
      bus.br_type = 3'd1;
      set_cmp(0);
      bus.imm = 32'd8;
      tick();
      chk("priority_pc", bus.pc, 32'h5000);
      do_reset();
      bus.stall = 1;
      bus.jump = 1;
      bus.j_index = 26'h0000C10;
      tick();
      rst_n = 0;
      tick();
      rst_n = 1;
      idle();
      tick();
      chk("rst_mid_stall_pc", bus.pc, 32'h3004);
      chk("rst_mid_stall_redirect", 32'(bus.redirect), 32'd0);
`ifdef PC_EXC_EN
      do_reset();
      repeat (4) tick();
      bus.stall = 1;
      bus.exc = 1;
      tick();
      chk("exc_pc", bus.pc, 32'h4180);
      chk("exc_epc", bus.epc, 32'h3010);
      idle();
      bus.eret = 1;
      tick();
      chk("eret_pc", bus.pc, 32'h3010);
      idle();
`endif
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rst_n = ($urandom_range(0, 49) != 0);
         bus.stall = ($urandom_range(0, 3) == 0);
         bus.br_type = 3'($urandom_range(0, 7));
         set_cmp(int'($urandom_range(0, 2)) - 1);
         bus.jump = ($urandom_range(0, 7) == 0);
         bus.jr = ($urandom_range(0, 7) == 0);
         bus.imm = 32'(int'($urandom_range(0, 64)) - 32);
         bus.j_index = 26'($urandom);
         bus.jr_target = $urandom;
`ifdef PC_EXC_EN
         bus.exc = ($urandom_range(0, 19) == 0);
         bus.eret = ($urandom_range(0, 11) == 0);
`endif
         tick();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
